dec_n_pipe: RTL and testbench

Parametrised, pipelined W-to-2^W one-hot decoder. Successor to the fixed 4-to-16 two-level decoder. Keeps the same two-level split: the upper bits predecode into group enables, and the lower bits decode within each group. Adds registered stages, a valid qualifier, and an optional self-driven scan mode that sweeps every output in turn. Used as the select and strobe generator for banked peripherals and for LED/row scanning.

---
 rtl/dec_pkg.sv | 27 ++
 rtl/dec_n_pipe_if.sv | 26 ++
 rtl/dec_scan_ctr.sv | 58 +++++
 rtl/dec_n_pipe.sv | 93 +++++++++
 tb/tb_dec_n_pipe.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the pipelined one-hot decoder and its scan counter.
package dec_pkg;

  localparam int unsigned DEC_MAX_N = 256;

  typedef enum logic {
    DEC_MODE_DECODE = 1'b0,
    DEC_MODE_SCAN   = 1'b1
  } dec_mode_e;

  function automatic int unsigned HI_W(input int unsigned w);
    return w / 2;
  endfunction

  function automatic int unsigned LO_W(input int unsigned w);
    return w - (w / 2);
  endfunction

  // One-hot of idx within an n-bit field; callers keep the low n bits.
  function automatic logic [DEC_MAX_N-1:0] onehot(input logic [7:0] idx, input int unsigned n);
    logic [DEC_MAX_N-1:0] r;
    r = '0;
    if (32'(idx) < n) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dec_n_pipe_if.sv
// Select/strobe bus of dec_n_pipe: requester drives select side, decoder drives result side.
interface dec_n_pipe_if #(
  parameter int unsigned W = 4
);
  import dec_pkg::*;

  logic              en;
  logic              in_valid;
  logic [W-1:0]      w;
  dec_mode_e         mode;
  logic              out_valid;
  logic [(1<<W)-1:0] y;
  logic [W-1:0]      scan_idx;
  logic              scan_wrap;

  modport master (
    output en, in_valid, w, mode,
    input  out_valid, y, scan_idx, scan_wrap
  );

  modport slave (
    input  en, in_valid, w, mode,
    output out_valid, y, scan_idx, scan_wrap
  );

endinterface

// File: rtl/dec_scan_ctr.sv
// Modulo-2^W index counter advancing every DWELL enabled cycles; freeze on en=0,
// held at zero while not running, registered wrap pulse on the 2^W-1 -> 0 step.
module dec_scan_ctr #(
  parameter int unsigned W     = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run_i,
  input  logic         en_i,
  output logic [W-1:0] idx_o,
  output logic         wrap_o
);

  localparam int unsigned DW_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0] IDX_MAX = '1;

  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [W-1:0]    idx_q, idx_d;
  logic            wrap_q, wrap_d;
  logic            term_c;

  // Outside scan the counters sit at zero, so entry always starts a clean sweep.
  always_comb begin
    dwell_d = dwell_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    term_c  = (dwell_q == DW_W'(DWELL - 1));
    if (!run_i) begin
      dwell_d = '0;
      idx_d   = '0;
    end else if (en_i) begin
      if (term_c) begin
        dwell_d = '0;
        idx_d   = idx_q + 1'b1;
        wrap_d  = (idx_q == IDX_MAX);
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
    end
  end

  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/dec_n_pipe.sv
// Two-stage W-to-2^W one-hot decoder (group predecode, then in-group decode).
// Optional self-driven scan sweep is built when DEC_SCAN_EN is defined.
module dec_n_pipe
  import dec_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  dec_n_pipe_if.slave  bus
);

  localparam int unsigned HI = HI_W(W);
  localparam int unsigned LO = LO_W(W);
  localparam int unsigned NG = 1 << HI;
  localparam int unsigned NL = 1 << LO;
  localparam int unsigned N  = 1 << W;

  logic [NG-1:0] g_en_q, g_en_d;
  logic [LO-1:0] lo_q, lo_d;
  logic          v1_q, v1_d;
  logic [N-1:0]  y_q, y_d;
  logic          out_valid_q;
  logic [W-1:0]  sel_c;
  logic          sel_valid_c;

`ifdef DEC_SCAN_EN
  logic         scan_c;
  logic [W-1:0] scan_idx;
  logic         scan_wrap;

  assign scan_c = (bus.mode == DEC_MODE_SCAN);

  dec_scan_ctr #(
    .W     (W),
    .DWELL (DWELL)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .run_i  (scan_c),
    .en_i   (bus.en),
    .idx_o  (scan_idx),
    .wrap_o (scan_wrap)
  );

  // Scan replaces the external select and forces a valid request every cycle.
  assign sel_c        = scan_c ? scan_idx : bus.w;
  assign sel_valid_c  = scan_c | bus.in_valid;
  assign bus.scan_idx = scan_idx;
  assign bus.scan_wrap = scan_wrap;
`else
  logic unused_mode;

  assign unused_mode   = bus.mode;
  assign sel_c         = bus.w;
  assign sel_valid_c   = bus.in_valid;
  assign bus.scan_idx  = '0;
  assign bus.scan_wrap = 1'b0;
`endif

  // Stage 1: predecode upper bits into group enables.
  for (genvar g = 0; g < NG; g++) begin : g_pre
    assign g_en_d[g] = bus.en && (sel_c[W-1:LO] == HI'(g));
  end
  assign lo_d = sel_c[LO-1:0];
  assign v1_d = sel_valid_c;

  // Stage 2: decode lower bits inside the single enabled group.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    assign y_d[g*NL +: NL] = (v1_q && g_en_q[g]) ? NL'(onehot(8'(lo_q), NL)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_en_q      <= '0;
      lo_q        <= '0;
      v1_q        <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      g_en_q      <= g_en_d;
      lo_q        <= lo_d;
      v1_q        <= v1_d;
      y_q         <= y_d;
      out_valid_q <= v1_q;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_dec_n_pipe.sv
// Randomised bench for dec_n_pipe against a cycle-level arithmetic model; instance 0 is
// W=4/DWELL=4, instance 1 (W=3/DWELL=2, scan sweep) exists when DEC_SCAN_EN is defined.
module tb_dec_n_pipe;
  import dec_pkg::*;

`ifdef DEC_SCAN_EN
  localparam int NI = 2;
  localparam bit SCAN_BUILT = 1'b1;
`else
  localparam int NI = 1;
  localparam bit SCAN_BUILT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  int nw[2] = '{4, 3};
  int dw[2] = '{4, 2};

  // Stimulus per instance
  logic m_en[2], m_iv[2], m_mode[2];
  int   m_w[2];

  // Observed DUT outputs, widened
  logic [15:0] a_y[2];
  logic        a_ov[2], a_wr[2];
  int          a_idx[2];

  // Model state: two result slots, scan progress counted in enabled scan cycles
  bit          p1v[2], p2v[2];
  logic [15:0] p1y[2], p2y[2];
  int          cnt[2];
  bit          wr_exp[2], last_mode[2];

  dec_n_pipe_if #(.W(4)) ifa ();
  assign ifa.en       = m_en[0];
  assign ifa.in_valid = m_iv[0];
  assign ifa.w        = 4'(m_w[0]);
  assign ifa.mode     = dec_mode_e'(m_mode[0]);
  assign a_y[0]   = ifa.y;
  assign a_ov[0]  = ifa.out_valid;
  assign a_wr[0]  = ifa.scan_wrap;
  assign a_idx[0] = int'(ifa.scan_idx);

  dec_n_pipe #(.W(4), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));

`ifdef DEC_SCAN_EN
  dec_n_pipe_if #(.W(3)) ifb ();
  assign ifb.en       = m_en[1];
  assign ifb.in_valid = m_iv[1];
  assign ifb.w        = 3'(m_w[1]);
  assign ifb.mode     = dec_mode_e'(m_mode[1]);
  assign a_y[1]   = {8'h00, ifb.y};
  assign a_ov[1]  = ifb.out_valid;
  assign a_wr[1]  = ifb.scan_wrap;
  assign a_idx[1] = int'(ifb.scan_idx);

  dec_n_pipe #(.W(3), .DWELL(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
`else
  assign a_y[1]   = 16'h0;
  assign a_ov[1]  = 1'b0;
  assign a_wr[1]  = 1'b0;
  assign a_idx[1] = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int k, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: the selected output is 1<<sel two edges after sampling; scan index is
  // (enabled scan cycles / DWELL) mod 2^W.
  task automatic step(input int k);
    int n, sel;
    bit scan, v;
    n    = 1 << nw[k];
    scan = SCAN_BUILT && m_mode[k];
    if (rst) begin
      p1v[k] = 0; p2v[k] = 0; p1y[k] = '0; p2y[k] = '0;
      cnt[k] = 0; wr_exp[k] = 0; last_mode[k] = 0;
    end else begin
      p2v[k] = p1v[k];
      p2y[k] = p1y[k];
      if (scan) begin
        sel = (cnt[k] / dw[k]) % n;
        v   = 1'b1;
        if (m_en[k]) begin
          cnt[k]++;
          wr_exp[k] = (cnt[k] % (n * dw[k]) == 0);
        end else begin
          wr_exp[k] = 1'b0;
        end
      end else begin
        sel = m_w[k];
        v   = m_iv[k];
        cnt[k] = 0;
        wr_exp[k] = 1'b0;
      end
      p1v[k] = v;
      p1y[k] = m_en[k] ? 16'(1 << sel) : 16'h0;
      last_mode[k] = scan;
    end
  endtask

  task automatic check_k(input int k);
    logic [15:0] ey;
    ey = p2v[k] ? p2y[k] : 16'h0;
    cmp("out_valid", k, a_ov[k], p2v[k]);
    cmp("y", k, a_y[k], ey);
    cmp("onehot_inv", k, ($countones(a_y[k]) <= 1), 1);
    cmp("scan_wrap", k, a_wr[k], wr_exp[k]);
    if (last_mode[k] || !SCAN_BUILT)
      cmp("scan_idx", k, a_idx[k], last_mode[k] ? (cnt[k] / dw[k]) % (1 << nw[k]) : 0);
  endtask

  always @(posedge clk) for (int k = 0; k < NI; k++) step(k);

  always @(negedge clk) if (chk_on) for (int k = 0; k < NI; k++) check_k(k);

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_en[k] = 0; m_iv[k] = 0; m_mode[k] = 0; m_w[k] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    cmp("reset_y", 0, a_y[0], 16'h0);
    cmp("reset_ov", 0, a_ov[0], 0);
    cmp("reset_idx", 0, a_idx[0], 0);
    rst = 1'b0;

    // Single select 0xA: nothing for one cycle, then bit 10 on the second.
    m_iv[0] = 1; m_en[0] = 1; m_w[0] = 10;
    @(negedge clk);
    m_iv[0] = 0;
    cmp("lat_pre_y", 0, a_y[0], 16'h0);
    cmp("lat_pre_ov", 0, a_ov[0], 0);
    @(negedge clk);
    cmp("lat_y", 0, a_y[0], 16'h0400);
    cmp("lat_ov", 0, a_ov[0], 1);

    // Back-to-back sweep of every select value
    for (int i = 0; i < 16; i++) begin
      m_iv[0] = 1; m_w[0] = i;
      @(negedge clk);
    end
    m_iv[0] = 0;
    @(negedge clk);
    cmp("b2b_last", 0, a_y[0], 16'h8000);

    // Disabled but valid gives a valid empty result
    m_en[0] = 0; m_iv[0] = 1; m_w[0] = 5;
    @(negedge clk);
    m_iv[0] = 0;
    @(negedge clk);
    cmp("en0_ov", 0, a_ov[0], 1);
    cmp("en0_y", 0, a_y[0], 16'h0);
    @(negedge clk);
    cmp("en0_nv_ov", 0, a_ov[0], 0);

    // Reset with both stages full
    m_en[0] = 1; m_iv[0] = 1; m_w[0] = 7;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("rst_mid_ov", 0, a_ov[0], 0);
    cmp("rst_mid_y", 0, a_y[0], 16'h0);
    rst = 1'b0; m_iv[0] = 0;
    repeat (3) @(negedge clk);

`ifndef DEC_SCAN_EN
    // Mode is ignored in the plain decoder build
    m_mode[0] = 1; m_iv[0] = 1; m_en[0] = 1; m_w[0] = 3;
    @(negedge clk);
    m_iv[0] = 0;
    @(negedge clk);
    cmp("noscan_y", 0, a_y[0], 16'h0008);
    cmp("noscan_idx", 0, a_idx[0], 0);
    cmp("noscan_wrap", 0, a_wr[0], 0);
    m_mode[0] = 0;
`endif

    // Randomised traffic, occasional reset and mode switches
    for (int i = 0; i < 400; i++) begin
      m_en[0] = ($urandom_range(0, 7) != 0);
      m_iv[0] = $urandom_range(0, 1);
      m_w[0]  = $urandom_range(0, 15);
      if ($urandom_range(0, 29) == 0) m_mode[0] = ~m_mode[0];
      rst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    rst = 1'b0; m_mode[0] = 0; m_iv[0] = 0;
    repeat (3) @(negedge clk);

`ifdef DEC_SCAN_EN
    begin
      int wraps;
      int frozen;
      m_mode[1] = 1; m_en[1] = 1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 18; i++) begin
        cmp("scan_seq", 1, a_y[1], 16'(1 << ((i / 2) % 8)));
        @(negedge clk);
      end
      wraps = 0;
      for (int i = 0; i < 32; i++) begin
        if (a_wr[1]) wraps++;
        @(negedge clk);
      end
      cmp("wrap_count", 1, wraps, 2);
      repeat (5) @(negedge clk);
      frozen = a_idx[1];
      m_en[1] = 0;
      repeat (5) @(negedge clk);
      cmp("freeze_idx", 1, a_idx[1], frozen);
      cmp("freeze_y", 1, a_y[1], 16'h0);
      m_en[1] = 1;
      repeat (20) @(negedge clk);
      m_mode[1] = 0; m_iv[1] = 1; m_w[1] = 6;
      repeat (3) @(negedge clk);
      cmp("leave_scan_y", 1, a_y[1], 16'h0040);
      m_iv[1] = 0;
      repeat (3) @(negedge clk);
    end
`endif

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
